// File: rtl/fft_pkg.sv
// Shared types and fixed-point helpers for the pipelined radix-2 butterfly.
// Helpers work on a 64-bit signed carrier so they serve any data/twiddle width up to that size.
package fft_pkg;
  localparam int WIDTH_DEF    = 16;
  localparam int TW_WIDTH_DEF = 16;
  localparam int TAG_W_DEF    = 8;

  typedef enum logic {BF_DIT = 1'b0, BF_DIF = 1'b1} bf_mode_e;

  typedef struct packed {
    logic signed [WIDTH_DEF-1:0] re;
    logic signed [WIDTH_DEF-1:0] im;
  } cplx_t;

  typedef logic signed [63:0] acc_t;

  // Arithmetic right shift by sh with round-half-up (adds half an LSB of the result first).
  function automatic acc_t rnd_shr(input acc_t v, input int sh);
    return (v + (acc_t'(1) <<< (sh - 1))) >>> sh;
  endfunction

  function automatic acc_t sat_clip(input acc_t v, input int w);
    acc_t hi;
    acc_t lo;
    hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
    lo = -(acc_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic sat_hit(input acc_t v, input int w);
    return v != sat_clip(v, w);
  endfunction
endpackage

// File: rtl/fft_butterfly_pipe_if.sv
// Input and output valid/ready streams of the pipelined butterfly.
interface fft_butterfly_pipe_if #(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16,
  parameter int TAG_W    = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic signed [WIDTH-1:0]    in_a_re, in_a_im, in_b_re, in_b_im;
  logic signed [TW_WIDTH-1:0] in_w_re, in_w_im;
  logic                       in_dif;
  logic                       in_scale;
  logic [TAG_W-1:0]           in_tag;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [WIDTH-1:0]    out_x_re, out_x_im, out_y_re, out_y_im;
  logic [TAG_W-1:0]           out_tag;

  modport master (
    output in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_w_re, in_w_im,
           in_dif, in_scale, in_tag, out_ready,
    input  in_ready, out_valid, out_x_re, out_x_im, out_y_re, out_y_im, out_tag
  );

  modport slave (
    input  in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_w_re, in_w_im,
           in_dif, in_scale, in_tag, out_ready,
    output in_ready, out_valid, out_x_re, out_x_im, out_y_re, out_y_im, out_tag
  );
endinterface

// File: rtl/fft_butterfly_pipe_cmul.sv
// Two-stage complex multiply b*W: full products registered, then rounded back to Q1.x scale.
module bf_cmul
  import fft_pkg::*;
#(
  parameter int BW = 17,
  parameter int TW = 16,
  parameter int RW = 19
) (
  input  logic                 clk,
  input  logic                 en1_i,
  input  logic                 en2_i,
  input  logic signed [BW-1:0] b_re_i,
  input  logic signed [BW-1:0] b_im_i,
  input  logic signed [TW-1:0] w_re_i,
  input  logic signed [TW-1:0] w_im_i,
  output logic signed [RW-1:0] wb_re_o,
  output logic signed [RW-1:0] wb_im_o
);
  localparam int PW = BW + TW;
  localparam int SW = PW + 1;

  logic signed [PW-1:0] m1_q, m2_q, m3_q, m4_q;
  logic signed [SW-1:0] re_sum, im_sum;
  logic signed [RW-1:0] wb_re_q, wb_im_q;

  // stage 1: full-precision partial products
  always_ff @(posedge clk) begin
    if (en1_i) begin
      m1_q <= PW'(b_re_i) * PW'(w_re_i);
      m2_q <= PW'(b_im_i) * PW'(w_im_i);
      m3_q <= PW'(b_re_i) * PW'(w_im_i);
      m4_q <= PW'(b_im_i) * PW'(w_re_i);
    end
  end

  assign re_sum = SW'(m1_q) - SW'(m2_q);
  assign im_sum = SW'(m3_q) + SW'(m4_q);

  // stage 2: drop the twiddle fraction bits with round-half-up
  always_ff @(posedge clk) begin
    if (en2_i) begin
      wb_re_q <= RW'(rnd_shr(acc_t'(re_sum), TW - 1));
      wb_im_q <= RW'(rnd_shr(acc_t'(im_sum), TW - 1));
    end
  end

  assign wb_re_o = wb_re_q;
  assign wb_im_o = wb_im_q;
endmodule

// File: rtl/fft_butterfly_pipe.sv
// Pipelined radix-2 DIT/DIF butterfly, 3 register stages with valid/ready backpressure.
// The multiplier operand is chosen at the input (b for DIT, a-b for DIF) so one bf_cmul serves both modes.
module fft_butterfly_pipe
  import fft_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int TW_WIDTH = TW_WIDTH_DEF,
  parameter int TAG_W    = TAG_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft_butterfly_pipe_if.slave  bf,
  input  logic                 ovf_clr,
  output logic                 ovf_sticky
);
  localparam int BW = WIDTH + 1;
  localparam int RW = WIDTH + 3;
  localparam int XW = WIDTH + 4;

  logic vld_p1_q, vld_p2_q, vld_p3_q;
  logic rdy1, rdy2, rdy3, ld1, ld2, ld3;

  assign rdy3        = !vld_p3_q || bf.out_ready;
  assign rdy2        = !vld_p2_q || rdy3;
  assign rdy1        = !vld_p1_q || rdy2;
  assign ld1         = rdy1 && bf.in_valid;
  assign ld2         = rdy2 && vld_p1_q;
  assign ld3         = rdy3 && vld_p2_q;
  assign bf.in_ready = rdy1;

  logic signed [BW-1:0] a_re_x, a_im_x, b_re_x, b_im_x;
  logic signed [BW-1:0] cb_re, cb_im, base_re_d, base_im_d;
  logic signed [BW-1:0] base_re_p1_q, base_im_p1_q, base_re_p2_q, base_im_p2_q;
  bf_mode_e             mode_p1_q, mode_p2_q;
  logic                 scale_p1_q, scale_p2_q;
  logic [TAG_W-1:0]     tag_p1_q, tag_p2_q;
  logic signed [RW-1:0] wb_re, wb_im;

  assign a_re_x    = BW'(bf.in_a_re);
  assign a_im_x    = BW'(bf.in_a_im);
  assign b_re_x    = BW'(bf.in_b_re);
  assign b_im_x    = BW'(bf.in_b_im);
  assign cb_re     = bf.in_dif ? (a_re_x - b_re_x) : b_re_x;
  assign cb_im     = bf.in_dif ? (a_im_x - b_im_x) : b_im_x;
  assign base_re_d = bf.in_dif ? (a_re_x + b_re_x) : a_re_x;
  assign base_im_d = bf.in_dif ? (a_im_x + b_im_x) : a_im_x;

  bf_cmul #(.BW(BW), .TW(TW_WIDTH), .RW(RW)) u_cmul (
    .clk     (clk),
    .en1_i   (ld1),
    .en2_i   (ld2),
    .b_re_i  (cb_re),
    .b_im_i  (cb_im),
    .w_re_i  (bf.in_w_re),
    .w_im_i  (bf.in_w_im),
    .wb_re_o (wb_re),
    .wb_im_o (wb_im)
  );

  // S1/S2: side-band and the additive operand travel alongside the multiplier
  always_ff @(posedge clk) begin
    if (ld1) begin
      base_re_p1_q <= base_re_d;
      base_im_p1_q <= base_im_d;
      mode_p1_q    <= bf.in_dif ? BF_DIF : BF_DIT;
      scale_p1_q   <= bf.in_scale;
      tag_p1_q     <= bf.in_tag;
    end
    if (ld2) begin
      base_re_p2_q <= base_re_p1_q;
      base_im_p2_q <= base_im_p1_q;
      mode_p2_q    <= mode_p1_q;
      scale_p2_q   <= scale_p1_q;
      tag_p2_q     <= tag_p1_q;
    end
  end

  function automatic acc_t scaled(input logic signed [XW-1:0] v, input logic sc);
    return sc ? rnd_shr(acc_t'(v), 1) : acc_t'(v);
  endfunction

  logic signed [XW-1:0] xr_w, xi_w, yr_w, yi_w;
  acc_t                 xr_s, xi_s, yr_s, yi_s;
  logic signed [WIDTH-1:0] x_re_d, x_im_d, y_re_d, y_im_d;
  logic                 ovf_hit;

  // S3 input: butterfly add/sub, optional halving, saturation
  always_comb begin
    if (mode_p2_q == BF_DIF) begin
      xr_w = XW'(base_re_p2_q);
      xi_w = XW'(base_im_p2_q);
      yr_w = XW'(wb_re);
      yi_w = XW'(wb_im);
    end else begin
      xr_w = XW'(base_re_p2_q) + XW'(wb_re);
      xi_w = XW'(base_im_p2_q) + XW'(wb_im);
      yr_w = XW'(base_re_p2_q) - XW'(wb_re);
      yi_w = XW'(base_im_p2_q) - XW'(wb_im);
    end
    xr_s    = scaled(xr_w, scale_p2_q);
    xi_s    = scaled(xi_w, scale_p2_q);
    yr_s    = scaled(yr_w, scale_p2_q);
    yi_s    = scaled(yi_w, scale_p2_q);
    x_re_d  = WIDTH'(sat_clip(xr_s, WIDTH));
    x_im_d  = WIDTH'(sat_clip(xi_s, WIDTH));
    y_re_d  = WIDTH'(sat_clip(yr_s, WIDTH));
    y_im_d  = WIDTH'(sat_clip(yi_s, WIDTH));
    ovf_hit = sat_hit(xr_s, WIDTH) || sat_hit(xi_s, WIDTH) ||
              sat_hit(yr_s, WIDTH) || sat_hit(yi_s, WIDTH);
  end

  logic signed [WIDTH-1:0] x_re_q, x_im_q, y_re_q, y_im_q;
  logic [TAG_W-1:0]        tag_q;
  logic                    ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      x_re_q   <= '0;
      x_im_q   <= '0;
      y_re_q   <= '0;
      y_im_q   <= '0;
      tag_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (rdy1) vld_p1_q <= bf.in_valid;
      if (rdy2) vld_p2_q <= vld_p1_q;
      if (rdy3) vld_p3_q <= vld_p2_q;
      if (ld3) begin
        x_re_q <= x_re_d;
        x_im_q <= x_im_d;
        y_re_q <= y_re_d;
        y_im_q <= y_im_d;
        tag_q  <= tag_p2_q;
      end
      if (ld3 && ovf_hit) ovf_q <= 1'b1;
      else if (ovf_clr)   ovf_q <= 1'b0;
    end
  end

  assign bf.out_valid = vld_p3_q;
  assign bf.out_x_re  = x_re_q;
  assign bf.out_x_im  = x_im_q;
  assign bf.out_y_re  = y_re_q;
  assign bf.out_y_im  = y_im_q;
  assign bf.out_tag   = tag_q;
  assign ovf_sticky   = ovf_q;
endmodule
